// File: rtl/lsu.sv
// Load/store unit: one req/ack data-memory transaction per accepted request,
// with store lane steering and sign/zero extension of load data.
module lsu #(
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic        iwClk,
    input  logic        iwRst,
    input  logic        iwValid,
    output logic        owReady,
    input  logic        iwWrite,
    input  logic [1:0]  iwSize,
    input  logic        iwUnsigned,
    input  logic [31:0] iwAddr,
    input  logic [31:0] iwWData,
    output logic        owDone,
    output logic [31:0] owRData,
    output logic        owFault,
    output logic        owMemReq,
    output logic        owMemWe,
    output logic [31:0] owMemAddr,
    output logic [3:0]  owMemBe,
    output logic [31:0] owMemWData,
    input  logic        iwMemAck,
    input  logic [31:0] iwMemRData
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    // Last counter value before the timeout fires; unused when MEM_WAIT_MAX is 0.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);
    localparam logic       WAIT_EN   = (MEM_WAIT_MAX != 0);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [1:0]  off_q, off_d;
    logic [29:0] waddr_q, waddr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic        fault_q, fault_d;
    logic [31:0] rdata_q, rdata_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        illegal;
    logic [3:0]  be_acc;
    logic [31:0] wdata_acc;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_ext;

    always_comb begin
        illegal = (iwSize == 2'd3) ||
                  (iwSize == 2'd1 && iwAddr[0]) ||
                  (iwSize == 2'd2 && iwAddr[1:0] != 2'b00);
        case (iwSize)
            2'd0:    be_acc = 4'b0001 << iwAddr[1:0];
            2'd1:    be_acc = iwAddr[1] ? 4'b1100 : 4'b0011;
            default: be_acc = 4'b1111;
        endcase
        wdata_acc = '0;
        if (iwWrite) begin
            case (iwSize)
                2'd0:    wdata_acc = {4{iwWData[7:0]}};
                2'd1:    wdata_acc = {2{iwWData[15:0]}};
                default: wdata_acc = iwWData;
            endcase
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = iwMemRData[7:0];
            2'd1:    ld_byte = iwMemRData[15:8];
            2'd2:    ld_byte = iwMemRData[23:16];
            default: ld_byte = iwMemRData[31:24];
        endcase
        ld_half = off_q[1] ? iwMemRData[31:16] : iwMemRData[15:0];
        case (size_q)
            2'd0:    ld_ext = {{24{ld_byte[7] & ~uns_q}}, ld_byte};
            2'd1:    ld_ext = {{16{ld_half[15] & ~uns_q}}, ld_half};
            default: ld_ext = iwMemRData;
        endcase
    end

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        size_d  = size_q;
        uns_d   = uns_q;
        off_d   = off_q;
        waddr_d = waddr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        fault_d = fault_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (iwValid) begin
                    we_d    = iwWrite;
                    size_d  = iwSize;
                    uns_d   = iwUnsigned;
                    off_d   = iwAddr[1:0];
                    waddr_d = iwAddr[31:2];
                    be_d    = be_acc;
                    wdata_d = wdata_acc;
                    fault_d = illegal;
                    cnt_d   = '0;
                    state_d = illegal ? DONE : BUS;
                end
            end
            BUS: begin
                if (iwMemAck) begin
                    if (!we_q) rdata_d = ld_ext;
                    state_d = DONE;
                end else if (WAIT_EN && cnt_q == WAIT_LAST) begin
                    fault_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iwClk or posedge iwRst) begin
        if (iwRst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            off_q   <= '0;
            waddr_q <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
            rdata_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            off_q   <= off_d;
            waddr_q <= waddr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            fault_q <= fault_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bus outputs are gated by BUS so they read as zero whenever no request is open.
    assign owReady    = (state_q == IDLE);
    assign owMemReq   = (state_q == BUS);
    assign owMemWe    = owMemReq & we_q;
    assign owMemAddr  = owMemReq ? {waddr_q, 2'b00} : 32'd0;
    assign owMemBe    = owMemReq ? be_q : 4'd0;
    assign owMemWData = owMemReq ? wdata_q : 32'd0;
    assign owDone     = (state_q == DONE);
    assign owFault    = owDone & fault_q;
    assign owRData    = rdata_q;

endmodule
